// File: rtl/tea_iter_core.sv
// Iterative TEA cipher engine: ROUNDS rounds per block, UNROLL chained rounds per clock.
// Latency: accept at edge N -> out_valid after edge N+ROUNDS/UNROLL; one block in flight.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE, no queueing.
// Build option: define TEA_ENCRYPT_EN to add the encrypt datapath (in_mode selects);
// without it only decrypt is built and in_mode is ignored.
module tea_iter_core #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_key,
  input  logic [63:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy
);

  localparam int CW = $clog2(ROUNDS) + 1;
  localparam logic [CW-1:0] CNT_STEP = CW'(UNROLL);
  localparam logic [CW-1:0] CNT_END  = CW'(ROUNDS);
  // Decrypt walks the sum schedule backwards from its final encrypt value.
  localparam logic [31:0] SUM_DEC_INIT = DELTA * ROUNDS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic          armed;   // low only until the first edge after reset release
  logic [127:0]  key_q;
  logic [31:0]   v0_q, v1_q, sum_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic [31:0]   nv0, nv1, nsum;
  logic [31:0]   k0, k1, k2, k3;
  logic [31:0]   sum_init;

`ifdef TEA_ENCRYPT_EN
  logic          mode_q;
`else
  logic          unused_mode;
  assign unused_mode = in_mode;
`endif

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // TEA Feistel mixing term shared by both directions.
  function automatic logic [31:0] mix(input logic [31:0] v, input logic [31:0] s,
                                      input logic [31:0] ka, input logic [31:0] kb);
    mix = ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  assign in_ready = armed && (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign cnt_nxt  = cnt_q + CNT_STEP;

`ifdef TEA_ENCRYPT_EN
  assign sum_init = in_mode ? DELTA : SUM_DEC_INIT;
`else
  assign sum_init = SUM_DEC_INIT;
`endif

  // Chain UNROLL rounds combinationally from the current registered state.
  always_comb begin
    nv0  = v0_q;
    nv1  = v1_q;
    nsum = sum_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
`ifdef TEA_ENCRYPT_EN
      if (mode_q) begin
        nv0  = nv0 + mix(nv1, nsum, k0, k1);
        nv1  = nv1 + mix(nv0, nsum, k2, k3);
        nsum = nsum + DELTA;
      end else begin
        nv1  = nv1 - mix(nv0, nsum, k2, k3);
        nv0  = nv0 - mix(nv1, nsum, k0, k1);
        nsum = nsum - DELTA;
      end
`else
      nv1  = nv1 - mix(nv0, nsum, k2, k3);
      nv0  = nv0 - mix(nv1, nsum, k0, k1);
      nsum = nsum - DELTA;
`endif
    end
  end

  // Control FSM plus the block, key, sum and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      key_q     <= '0;
      v0_q      <= '0;
      v1_q      <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef TEA_ENCRYPT_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            key_q  <= in_key;
            v0_q   <= in_data[63:32];
            v1_q   <= in_data[31:0];
            sum_q  <= sum_init;
            cnt_q  <= '0;
`ifdef TEA_ENCRYPT_EN
            mode_q <= in_mode;
`endif
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          v0_q  <= nv0;
          v1_q  <= nv1;
          sum_q <= nsum;
          cnt_q <= cnt_nxt;
          if (cnt_nxt == CNT_END) begin
            out_data  <= {nv0, nv1};
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_iter_core.sv
// Bench for tea_iter_core: two instances (UNROLL=1 and UNROLL=4), scoreboard-checked.
// Stimulus pushes expected results; per-instance monitors pop and compare on each handshake.
// Covers reset values, known vectors, latency, backpressure, mid-run reset, random round trips.
module tb_tea_iter_core;

  localparam logic [31:0] DELTA = 32'h9E3779B9;
  localparam logic [63:0] KV_CT = 64'h41EA3A0A_94BAA940;
  localparam logic [127:0] BK   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [63:0]  BP_PT = 64'h01234567_89ABCDEF;

  typedef struct packed {
    logic [63:0] d;
    int          acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [2];
  logic         in_mode   [2];
  logic [127:0] in_key    [2];
  logic [63:0]  in_data   [2];
  logic         out_ready [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic [63:0]  out_data  [2];
  logic         busy      [2];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   hs_cnt [2];
  exp_t sb [2][$];

  tea_iter_core #(.ROUNDS(32), .UNROLL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]),
    .in_key(in_key[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );

  tea_iter_core #(.ROUNDS(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]),
    .in_key(in_key[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Textbook TEA encrypt (sum pre-incremented each cycle), 32 cycles.
  function automatic logic [63:0] ref_enc(input logic [127:0] k, input logic [63:0] d);
    logic [31:0] y, z, s;
    y = d[63:32];
    z = d[31:0];
    s = 32'h0;
    for (int r = 0; r < 32; r++) begin
      s = s + DELTA;
      y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out (t=%0t)", name, $time);
  endtask

  // Offer one block; returns at posedge+1 after the accept edge.
  task automatic send(input int idx, input logic mode, input logic [127:0] k,
                      input logic [63:0] d, input logic [63:0] expd);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready[idx] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      bad("send_wait_ready");
    end else begin
      in_valid[idx] = 1'b1;
      in_mode[idx]  = mode;
      in_key[idx]   = k;
      in_data[idx]  = d;
      e.d   = expd;
      e.acc = cyc + 1;
      sb[idx].push_back(e);
      @(posedge clk); #1;
      in_valid[idx] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0 || busy[0] || busy[1]) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) bad("drain");
  endtask

  // Output monitor: latency measured from accept to first out_valid cycle.
  task automatic mon(input int idx);
    bit   prev;
    int   rise;
    int   lat;
    exp_t e;
    prev = 1'b0;
    rise = 0;
    lat  = (idx == 0) ? 32 : 8;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (out_valid[idx] && !prev) rise = cyc;
        if (out_valid[idx] && out_ready[idx]) begin
          hs_cnt[idx]++;
          if (sb[idx].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output inst=%0d actual=%h required=none", idx, out_data[idx]);
          end else begin
            e = sb[idx].pop_front();
            chk($sformatf("out_data_u%0d", idx), out_data[idx], e.d);
            chk($sformatf("latency_u%0d", idx), 64'(rise - e.acc), 64'(lat));
          end
        end
        prev = out_valid[idx];
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Random round trips on one instance.
  task automatic rand_trips(input int idx, input int count);
    logic [127:0] k;
    logic [63:0]  d, ct;
    for (int i = 0; i < count; i++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      d  = {$urandom, $urandom};
      ct = ref_enc(k, d);
`ifdef TEA_ENCRYPT_EN
      send(idx, 1'b1, k, d, ct);
      send(idx, 1'b0, k, ct, d);
`else
      send(idx, 1'($urandom_range(0, 1)), k, ct, d);
`endif
    end
  endtask

  initial begin
    int n;
    int hs0;
    logic [63:0] bp_ct;
    rst_n = 1'b0;
    hs_cnt[0] = 0;
    hs_cnt[1] = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_mode[i]   = 1'b0;
      in_key[i]    = '0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
    end

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_out_data", out_data[i], 64'h0);
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_in_ready_low", 64'(in_ready[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release_u1", 64'(in_ready[0]), 64'd1);
    chk("in_ready_after_release_u4", 64'(in_ready[1]), 64'd1);

    // Known vectors on both unroll settings
    for (int i = 0; i < 2; i++) begin
`ifdef TEA_ENCRYPT_EN
      send(i, 1'b1, 128'h0, 64'h0, KV_CT);
`endif
      send(i, 1'b0, 128'h0, KV_CT, 64'h0);
`ifndef TEA_ENCRYPT_EN
      send(i, 1'b1, 128'h0, KV_CT, 64'h0);
`endif
    end
    drain();

    // Backpressure on the UNROLL=4 instance
    bp_ct = ref_enc(BK, BP_PT);
    out_ready[1] = 1'b0;
    send(1, 1'b0, BK, bp_ct, BP_PT);
    n = 0;
    while (!out_valid[1] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) bad("bp_wait_valid");
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_data_stable", out_data[1], BP_PT);
      chk("bp_in_ready_low", 64'(in_ready[1]), 64'd0);
      chk("bp_out_valid_held", 64'(out_valid[1]), 64'd1);
      if (i == 3) begin
        in_valid[1] = 1'b1;
        in_data[1]  = 64'hDEADBEEF_CAFEF00D;
      end
      if (i == 4) in_valid[1] = 1'b0;
      @(posedge clk); #1;
    end
    in_valid[1] = 1'b0;
    hs0 = hs_cnt[1];
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_release", 64'(in_ready[1]), 64'd1);
    chk("bp_out_valid_cleared", 64'(out_valid[1]), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_single_handshake", 64'(hs_cnt[1] - hs0), 64'd1);
    chk("bp_pulse_ignored_idle", 64'(busy[1]), 64'd0);

    // Random round trips on both instances concurrently
    fork
      rand_trips(0, 200);
      rand_trips(1, 1000);
    join
    drain();

    // Reset at cycle 15 of the run
    send(0, 1'b0, BK, bp_ct, BP_PT);
    repeat (14) @(posedge clk);
    #1;
    chk("midrun_busy", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    sb[0].delete();
    sb[1].delete();
    @(posedge clk); #1;
    chk("midrun_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrun_rst_out_data", out_data[0], 64'h0);
    chk("midrun_rst_in_ready", 64'(in_ready[0]), 64'd0);
    chk("midrun_rst_busy", 64'(busy[0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("post_rst_out_data", out_data[0], 64'h0);
    repeat (40) @(posedge clk);
    #1;
    chk("aborted_no_output", 64'(hs_cnt[0] + 0), 64'(hs_cnt[0]));
    send(0, 1'b0, 128'h0, KV_CT, 64'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
